cpu_run_monitor: RTL and testbench

Parametrised simulation/bring-up monitor that sits beside the multicycle `CPU` and replaces fixed-duration, free-running test control. It sequences the core's reset, then counts cycles and retired instructions. It detects a program halt (ebreak or a self-loop) or a watchdog timeout, and records register writebacks into a circular trace buffer that a bench can read back after `done`.

---
 rtl/cpu_mon_pkg.sv | 19 +
 rtl/cpu_run_monitor_if.sv | 20 ++
 rtl/trace_ring.sv | 63 ++++++
 rtl/cpu_run_monitor.sv | 115 +++++++++++
 tb/tb_cpu_run_monitor.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_mon_pkg.sv
// Shared definitions for the CPU run monitor.
// Status encoding, FSM state type and the halt opcode.
package cpu_mon_pkg;

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_TOUT = 2'd3;

    localparam logic [31:0] EBREAK = 32'h00100073;

    typedef enum logic [1:0] {
        S_HOLD = ST_HOLD,
        S_RUN  = ST_RUN,
        S_HALT = ST_HALT,
        S_TOUT = ST_TOUT
    } mon_state_e;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Retirement bundle from the core to the monitor.
// The core drives it (master); the monitor observes it (slave).
interface cpu_run_monitor_if #(
    parameter int XLEN = 32
);
    logic            retire;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            RegWEn;
    logic [4:0]      rd;
    logic [XLEN-1:0] regDataIn;

    modport master (
        output retire, pc, instr, RegWEn, rd, regDataIn
    );

    modport slave (
        input retire, pc, instr, RegWEn, rd, regDataIn
    );
endinterface

// File: rtl/trace_ring.sv
// Circular writeback trace buffer.
// Read index 0 is the oldest valid entry; reads past count return 0.
module trace_ring #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      wrd,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] wpc,
    input  logic [AW-1:0]   idx,
    output logic [AW:0]     count,
    output logic            ovf,
    output logic [4:0]      rrd,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] rpc
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]   wptr;
    logic [AW-1:0]   slot;
    logic [4:0]      memRd   [DEPTH];
    logic [XLEN-1:0] memData [DEPTH];
    logic [XLEN-1:0] memPc   [DEPTH];

    // Pointer, fill level and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (we) begin
            wptr <= wptr + 1'b1;
            if (count == FULL) ovf <= 1'b1;
            else count <= count + 1'b1;
        end
    end

    // Entry storage; contents are only visible below count
    always_ff @(posedge clk) begin
        if (we) begin
            memRd[wptr]   <= wrd;
            memData[wptr] <= wdata;
            memPc[wptr]   <= wpc;
        end
    end

    // Oldest-relative read; a full ring wraps to wptr itself
    always_comb begin
        slot  = wptr - count[AW-1:0] + idx;
        rrd   = '0;
        rdata = '0;
        rpc   = '0;
        if ({1'b0, idx} < count) begin
            rrd   = memRd[slot];
            rdata = memData[slot];
            rpc   = memPc[slot];
        end
    end
endmodule

// File: rtl/cpu_run_monitor.sv
// Bring-up monitor: sequences core reset, counts cycles and
// retirements, detects halt/timeout and traces writebacks.
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter  int XLEN        = 32,
    parameter  int TRACE_DEPTH = 16,
    parameter  int RST_CYCLES  = 4,
    parameter  int MAX_CYCLES  = 150,
    parameter  int LOOP_REPEAT = 3,
    parameter  int CNT_W       = 16,
    localparam int AW          = $clog2(TRACE_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_run_monitor_if.slave     core,
    output logic                 cpuRstN,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_W-1:0]     cycleCnt,
    output logic [CNT_W-1:0]     retireCnt,
    output logic [AW:0]          traceCount,
    output logic                 traceOvf,
    input  logic [AW-1:0]        rdIdx,
    output logic [4:0]           trRd,
    output logic [XLEN-1:0]      trData,
    output logic [XLEN-1:0]      trPc
);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int RW = $clog2(LOOP_REPEAT + 1);
    localparam logic [HW-1:0]    HOLD_N = HW'(RST_CYCLES);
    localparam logic [RW-1:0]    LOOP_N = RW'(LOOP_REPEAT);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_CYCLES - 1);

    mon_state_e      state;
    mon_state_e      nxt;
    logic [HW-1:0]   holdCnt;
    logic [XLEN-1:0] lastPc;
    logic [RW-1:0]   repCnt;
    logic [RW-1:0]   repNxt;
    logic            run;
    logic            ret;
    logic            holdDone;
    logic            halt;
    logic            tout;
    logic            trWe;

    assign run      = (state == S_RUN);
    assign ret      = run && core.retire;
    assign holdDone = (holdCnt == HOLD_N);
    assign repNxt   = (core.pc == lastPc) ? repCnt + 1'b1 : RW'(1);
    assign halt     = ret && (core.instr == EBREAK || repNxt == LOOP_N);
    assign tout     = run && (cycleCnt == LAST_C);
    assign trWe     = ret && core.RegWEn && (core.rd != 5'd0);

    assign cpuRstN = (state != S_HOLD);
    assign done    = (state == S_HALT) || (state == S_TOUT);
    assign status  = state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_HOLD;
        else state <= nxt;
    end

    // Next state; halt wins over a coincident timeout
    always_comb begin
        nxt = state;
        unique case (state)
            S_HOLD: if (holdDone) nxt = S_RUN;
            S_RUN: begin
                if (halt) nxt = S_HALT;
                else if (tout) nxt = S_TOUT;
            end
            default: nxt = state;
        endcase
    end

    // Hold timer, saturating counters and loop tracker
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            holdCnt   <= '0;
            cycleCnt  <= '0;
            retireCnt <= '0;
            lastPc    <= '0;
            repCnt    <= '0;
        end else begin
            if (state == S_HOLD && !holdDone) holdCnt <= holdCnt + 1'b1;
            if (run && cycleCnt != '1) cycleCnt <= cycleCnt + 1'b1;
            if (ret) begin
                if (retireCnt != '1) retireCnt <= retireCnt + 1'b1;
                lastPc <= core.pc;
                repCnt <= repNxt;
            end
        end
    end

    trace_ring #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (trWe),
        .wrd   (core.rd),
        .wdata (core.regDataIn),
        .wpc   (core.pc),
        .idx   (rdIdx),
        .count (traceCount),
        .ovf   (traceOvf),
        .rrd   (trRd),
        .rdata (trData),
        .rpc   (trPc)
    );
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: a default instance and a
// TRACE_DEPTH=4 instance observe the same retirement stream.
module tb_cpu_run_monitor;
    logic clk;
    logic rst_n;

    cpu_run_monitor_if #(.XLEN(32)) bus ();

    logic        cpuRstN, done, traceOvf;
    logic [1:0]  status;
    logic [15:0] cycleCnt, retireCnt;
    logic [4:0]  traceCount;
    logic [3:0]  rdIdx;
    logic [4:0]  trRd;
    logic [31:0] trData, trPc;

    logic        cpuRstN4, done4, traceOvf4;
    logic [1:0]  status4;
    logic [15:0] cycleCnt4, retireCnt4;
    logic [2:0]  traceCount4;
    logic [1:0]  rdIdx4;
    logic [4:0]  trRd4;
    logic [31:0] trData4, trPc4;

    int nvec = 0;
    int nerr = 0;

    cpu_run_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .core(bus),
        .cpuRstN(cpuRstN), .done(done), .status(status),
        .cycleCnt(cycleCnt), .retireCnt(retireCnt),
        .traceCount(traceCount), .traceOvf(traceOvf),
        .rdIdx(rdIdx), .trRd(trRd), .trData(trData), .trPc(trPc)
    );

    cpu_run_monitor #(.TRACE_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .core(bus),
        .cpuRstN(cpuRstN4), .done(done4), .status(status4),
        .cycleCnt(cycleCnt4), .retireCnt(retireCnt4),
        .traceCount(traceCount4), .traceOvf(traceOvf4),
        .rdIdx(rdIdx4), .trRd(trRd4), .trData(trData4), .trPc(trPc4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire_one(input logic [31:0] p, input logic [31:0] ins,
                              input logic we, input logic [4:0] r,
                              input logic [31:0] d);
        bus.retire = 1'b1; bus.pc = p; bus.instr = ins;
        bus.RegWEn = we; bus.rd = r; bus.regDataIn = d;
        tick();
        bus.retire = 1'b0; bus.RegWEn = 1'b0;
    endtask

    task automatic start_run();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        nvec++; if (status !== 2'd0) begin nerr++; $display("FAIL rst_status got %0d exp 0", status); end
        nvec++; if (cpuRstN !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL rst_outs got cpuRstN=%b done=%b exp 0 0", cpuRstN, done); end
        nvec++; if (cycleCnt !== 16'd0 || retireCnt !== 16'd0 || traceCount !== 5'd0 || traceOvf !== 1'b0)
            begin nerr++; $display("FAIL rst_cnts got cyc=%0d ret=%0d tc=%0d ovf=%b exp 0", cycleCnt, retireCnt, traceCount, traceOvf); end
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            nvec++; if (cpuRstN !== 1'b0 || status !== 2'd0) begin nerr++; $display("FAIL hold_edge%0d got cpuRstN=%b status=%0d exp 0 0", i, cpuRstN, status); end
        end
        tick();
        nvec++; if (cpuRstN !== 1'b1 || status !== 2'd1) begin nerr++; $display("FAIL hold_release got cpuRstN=%b status=%0d exp 1 1", cpuRstN, status); end
        nvec++; if (cycleCnt !== 16'd0 || retireCnt !== 16'd0) begin nerr++; $display("FAIL run_start_cnts got cyc=%0d ret=%0d exp 0 0", cycleCnt, retireCnt); end
        tick();
        nvec++; if (cycleCnt !== 16'd1) begin nerr++; $display("FAIL run_cyc1 got %0d exp 1", cycleCnt); end
    endtask

    task automatic test_self_loop();
        start_run();
        retire_one(32'h00, 32'h13, 1'b1, 5'd1, 32'h11);
        retire_one(32'h04, 32'h13, 1'b1, 5'd2, 32'h22);
        retire_one(32'h08, 32'h13, 1'b1, 5'd3, 32'h33);
        retire_one(32'h0C, 32'h13, 1'b1, 5'd4, 32'h44);
        retire_one(32'h0C, 32'h13, 1'b1, 5'd4, 32'h44);
        nvec++; if (status !== 2'd1) begin nerr++; $display("FAIL loop_two got status=%0d exp 1", status); end
        retire_one(32'h0C, 32'h13, 1'b1, 5'd4, 32'h44);
        nvec++; if (status !== 2'd2 || done !== 1'b1) begin nerr++; $display("FAIL loop_halt got status=%0d done=%b exp 2 1", status, done); end
        nvec++; if (retireCnt !== 16'd6 || cycleCnt !== 16'd6) begin nerr++; $display("FAIL loop_cnts got ret=%0d cyc=%0d exp 6 6", retireCnt, cycleCnt); end
        nvec++; if (traceCount !== 5'd6) begin nerr++; $display("FAIL loop_trace got %0d exp 6", traceCount); end
        tick(); tick();
        nvec++; if (cycleCnt !== 16'd6 || status !== 2'd2 || cpuRstN !== 1'b1) begin nerr++; $display("FAIL loop_frozen got cyc=%0d status=%0d cpuRstN=%b exp 6 2 1", cycleCnt, status, cpuRstN); end
    endtask

    task automatic test_ebreak();
        start_run();
        retire_one(32'h10, 32'h00100073, 1'b0, 5'd0, 32'h0);
        nvec++; if (status !== 2'd2 || done !== 1'b1) begin nerr++; $display("FAIL ebreak_halt got status=%0d done=%b exp 2 1", status, done); end
        nvec++; if (retireCnt !== 16'd1) begin nerr++; $display("FAIL ebreak_ret got %0d exp 1", retireCnt); end
        retire_one(32'h14, 32'h13, 1'b1, 5'd5, 32'h55);
        nvec++; if (retireCnt !== 16'd1 || traceCount !== 5'd0) begin nerr++; $display("FAIL ebreak_ignore got ret=%0d tc=%0d exp 1 0", retireCnt, traceCount); end
    endtask

    task automatic test_timeout();
        start_run();
        repeat (149) tick();
        nvec++; if (status !== 2'd1 || cycleCnt !== 16'd149) begin nerr++; $display("FAIL tout_before got status=%0d cyc=%0d exp 1 149", status, cycleCnt); end
        tick();
        nvec++; if (status !== 2'd3 || done !== 1'b1) begin nerr++; $display("FAIL tout_state got status=%0d done=%b exp 3 1", status, done); end
        nvec++; if (cycleCnt !== 16'd150) begin nerr++; $display("FAIL tout_cyc got %0d exp 150", cycleCnt); end
        retire_one(32'h20, 32'h00100073, 1'b1, 5'd1, 32'h1);
        tick();
        nvec++; if (status !== 2'd3 || cycleCnt !== 16'd150 || retireCnt !== 16'd0) begin nerr++; $display("FAIL tout_frozen got status=%0d cyc=%0d ret=%0d exp 3 150 0", status, cycleCnt, retireCnt); end
    endtask

    task automatic test_trace_wrap();
        start_run();
        retire_one(32'h100, 32'h13, 1'b1, 5'd1, 32'hA1);
        rdIdx4 = 2'd0; #1;
        nvec++; if (traceCount4 !== 3'd1 || trRd4 !== 5'd1 || trData4 !== 32'hA1 || trPc4 !== 32'h100)
            begin nerr++; $display("FAIL tr_first got tc=%0d rd=%0d data=%h pc=%h exp 1 1 a1 100", traceCount4, trRd4, trData4, trPc4); end
        for (int i = 2; i <= 4; i++)
            retire_one(32'h100 + 32'(4*(i-1)), 32'h13, 1'b1, 5'(i), 32'hA0 + 32'(i));
        nvec++; if (traceCount4 !== 3'd4 || traceOvf4 !== 1'b0) begin nerr++; $display("FAIL tr_full got tc=%0d ovf=%b exp 4 0", traceCount4, traceOvf4); end
        for (int i = 5; i <= 6; i++)
            retire_one(32'h100 + 32'(4*(i-1)), 32'h13, 1'b1, 5'(i), 32'hA0 + 32'(i));
        retire_one(32'h200, 32'h13, 1'b1, 5'd0, 32'hBB);
        retire_one(32'h204, 32'h13, 1'b0, 5'd7, 32'hCC);
        nvec++; if (traceCount4 !== 3'd4 || traceOvf4 !== 1'b1) begin nerr++; $display("FAIL tr_wrap got tc=%0d ovf=%b exp 4 1", traceCount4, traceOvf4); end
        rdIdx4 = 2'd0; #1;
        nvec++; if (trRd4 !== 5'd3 || trData4 !== 32'hA3 || trPc4 !== 32'h108)
            begin nerr++; $display("FAIL tr_oldest got rd=%0d data=%h pc=%h exp 3 a3 108", trRd4, trData4, trPc4); end
        rdIdx4 = 2'd3; #1;
        nvec++; if (trRd4 !== 5'd6 || trData4 !== 32'hA6 || trPc4 !== 32'h114)
            begin nerr++; $display("FAIL tr_newest got rd=%0d data=%h pc=%h exp 6 a6 114", trRd4, trData4, trPc4); end
        nvec++; if (traceCount !== 5'd6 || traceOvf !== 1'b0 || retireCnt !== 16'd8)
            begin nerr++; $display("FAIL tr_filter got tc=%0d ovf=%b ret=%0d exp 6 0 8", traceCount, traceOvf, retireCnt); end
        rdIdx = 4'd5; #1;
        nvec++; if (trRd !== 5'd6 || trData !== 32'hA6) begin nerr++; $display("FAIL tr_idx5 got rd=%0d data=%h exp 6 a6", trRd, trData); end
        rdIdx = 4'd6; #1;
        nvec++; if (trRd !== 5'd0 || trData !== 32'h0 || trPc !== 32'h0) begin nerr++; $display("FAIL tr_empty_slot got rd=%0d data=%h pc=%h exp 0 0 0", trRd, trData, trPc); end
        rdIdx = 4'd0; rdIdx4 = 2'd0;
    endtask

    task automatic test_midrun_reset();
        retire_one(32'h0C, 32'h13, 1'b0, 5'd0, 32'h0);
        retire_one(32'h0C, 32'h13, 1'b0, 5'd0, 32'h0);
        nvec++; if (status4 !== 2'd1) begin nerr++; $display("FAIL mid_pre got status=%0d exp 1", status4); end
        rst_n = 1'b0;
        tick();
        nvec++; if (status4 !== 2'd0 || cpuRstN4 !== 1'b0 || done4 !== 1'b0) begin nerr++; $display("FAIL mid_state got status=%0d cpuRstN=%b done=%b exp 0 0 0", status4, cpuRstN4, done4); end
        nvec++; if (cycleCnt4 !== 16'd0 || retireCnt4 !== 16'd0 || traceCount4 !== 3'd0 || traceOvf4 !== 1'b0)
            begin nerr++; $display("FAIL mid_clear got cyc=%0d ret=%0d tc=%0d ovf=%b exp 0 0 0 0", cycleCnt4, retireCnt4, traceCount4, traceOvf4); end
        rst_n = 1'b1;
        repeat (5) tick();
        retire_one(32'h0C, 32'h13, 1'b0, 5'd0, 32'h0);
        retire_one(32'h0C, 32'h13, 1'b0, 5'd0, 32'h0);
        nvec++; if (status4 !== 2'd1 || retireCnt4 !== 16'd2) begin nerr++; $display("FAIL mid_loop_clear got status=%0d ret=%0d exp 1 2", status4, retireCnt4); end
    endtask

    task automatic test_simultaneous();
        start_run();
        repeat (149) tick();
        retire_one(32'h40, 32'h00100073, 1'b0, 5'd0, 32'h0);
        nvec++; if (status !== 2'd2 || done !== 1'b1) begin nerr++; $display("FAIL simul_halt got status=%0d done=%b exp 2 1", status, done); end
        nvec++; if (cycleCnt !== 16'd150 || retireCnt !== 16'd1) begin nerr++; $display("FAIL simul_cnts got cyc=%0d ret=%0d exp 150 1", cycleCnt, retireCnt); end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        bus.retire = 1'b0; bus.pc = '0; bus.instr = '0;
        bus.RegWEn = 1'b0; bus.rd = '0; bus.regDataIn = '0;
        rdIdx = '0; rdIdx4 = '0;
        test_reset();
        test_self_loop();
        test_ebreak();
        test_timeout();
        test_trace_wrap();
        test_midrun_reset();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
